uart_rx_sched: RTL and testbench

- Receive-side bit scheduler for the Bluetooth UART link.
- Owns a restartable baud counter that replaces the free-running divider on the receive path. The counter is re-phased on every start-bit edge, so sampling lands mid-bit.
- Sequences start/data/stop sampling, assembles 8N1 bytes and hands them to the consumer with a valid/ack handshake plus framing and overrun status.

---
 rtl/uart_rx_sched.sv | 137 +++++++++++++
 tb/tb_uart_rx_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sched.sv
// Receive-side bit scheduler for the Bluetooth UART link.
// A restartable baud counter is re-phased on every start-bit edge so that each
// sample lands mid-bit. 8N1 bytes are assembled and handed to the consumer
// through a valid/ack handshake that also reports framing errors and overruns.
module uart_rx_sched #(
  parameter int unsigned BIT_DIV  = 5208,
  parameter int unsigned HALF_DIV = BIT_DIV / 2,
  parameter int unsigned CNT_W    = $clog2(BIT_DIV)
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic       bit_tick
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic             rx_d;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             load_pend;

  assign fall = rx_d & ~rx_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Bit sequencer, baud counter, byte assembly and consumer handshake.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      load_pend <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      bit_tick  <= 1'b0;
    end else begin
      bit_tick  <= 1'b0;
      frame_err <= 1'b0;
      load_pend <= 1'b0;

      // The load is deferred one cycle after the stop sample; it takes
      // precedence over an ack arriving in the same cycle.
      if (load_pend) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
        overrun  <= rx_ack ? 1'b0 : (overrun | rx_valid);
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            bit_tick <= 1'b1;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            bit_tick <= 1'b1;
            shift    <= {rx_s, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            bit_tick <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            if (rx_s) load_pend <= 1'b1;
            else      frame_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sched.sv
// Self-checking bench for uart_rx_sched at 16 clocks per bit.
// A behavioural model tracks the consumer-visible byte, valid and overrun state
// from whole frames and acks; per-cycle observation counts ticks and pulses.
module tb_uart_rx_sched;

  localparam int unsigned BIT_DIV = 16;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic       bit_tick;

  uart_rx_sched #(.BIT_DIV(BIT_DIV)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy),
    .bit_tick (bit_tick)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model of what the consumer should see.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  // Observation history.
  int unsigned cyc_n         = 0;
  int unsigned tick_cnt      = 0;
  int unsigned ferr_cnt      = 0;
  int unsigned last_tick_cyc = 0;
  int unsigned rise_cyc      = 0;
  logic        prev_valid    = 1'b0;

  task automatic cyc();
    @(posedge clk_in);
    #1;
    cyc_n++;
    if (bit_tick) begin
      tick_cnt++;
      last_tick_cyc = cyc_n;
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && !prev_valid) rise_cyc = cyc_n;
    prev_valid = rx_valid;
  endtask

  task automatic model_load(input logic [7:0] b, input logic ack_at_load);
    if (ack_at_load)  m_ovr = 1'b0;
    else if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    cyc();
    rx_ack = 1'b0;
    model_ack();
  endtask

  // Drives one 8N1 frame; optionally pulses rx_ack in the cycle of the byte load
  // (the cycle right after the stop-bit tick is seen), then idles for gap cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input logic ack_load, input int unsigned gap);
    logic [9:0]  bits;
    int unsigned t0;
    logic        acked;
    bits  = {stop_b, b, 1'b0};
    t0    = tick_cnt;
    acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < int'(BIT_DIV); j++) begin
        cyc();
        if (rx_ack) rx_ack = 1'b0;
        else if (ack_load && !acked && (tick_cnt - t0 == 10)) begin
          rx_ack = 1'b1;
          acked  = 1'b1;
        end
      end
    end
    rx_ack = 1'b0;
    rx     = 1'b1;
    if (stop_b) model_load(b, ack_load);
    repeat (gap) cyc();
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bit_tick !== 1'b0) begin n_fail++; $display("FAIL reset_bit_tick: got %b expected 0", bit_tick); end
    repeat (2) cyc();
    reset = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_basic();
    int unsigned t0, f0;
    t0 = tick_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 4);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected 55", rx_data); end
    n_checks++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
    n_checks++; if (tick_cnt - t0 != 10) begin n_fail++; $display("FAIL basic_ticks: got %0d expected 10", tick_cnt - t0); end
    n_checks++; if (rise_cyc != last_tick_cyc + 1) begin n_fail++; $display("FAIL basic_valid_latency: got rise at %0d expected %0d", rise_cyc, last_tick_cyc + 1); end
    do_ack();
    n_checks++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL basic_ack_valid: got %b expected %b", rx_valid, m_valid); end
  endtask

  task automatic test_false_start();
    int unsigned t0, f0;
    t0 = tick_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) cyc();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_hi: got %b expected 1", busy); end
    rx = 1'b1;
    repeat (20) cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy: got %b expected 0", busy); end
    n_checks++; if (tick_cnt - t0 != 1) begin n_fail++; $display("FAIL false_start_ticks: got %0d expected 1", tick_cnt - t0); end
    n_checks++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL false_start_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_valid: got %b expected 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    int unsigned t0, f0;
    t0 = tick_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, 1'b0, 6);
    n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    n_checks++; if (tick_cnt - t0 != 10) begin n_fail++; $display("FAIL ferr_ticks: got %0d expected 10", tick_cnt - t0); end
    n_checks++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL ferr_valid: got %b expected %b", rx_valid, m_valid); end
    n_checks++; if (rx_data !== m_data) begin n_fail++; $display("FAIL ferr_data: got %h expected %h", rx_data, m_data); end
    send_frame(8'h3C, 1'b1, 1'b0, 4);
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_data: got %h expected 3c", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_recover_valid: got %b expected 1", rx_valid); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 3);
    n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h expected 22", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    do_ack();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b expected 0", rx_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_ack_on_load();
    send_frame(8'h5A, 1'b1, 1'b0, 2);
    send_frame(8'hC3, 1'b1, 1'b1, 3);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ackload_valid: got %b expected 1", rx_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ackload_overrun: got %b expected 0", overrun); end
    n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL ackload_data: got %h expected c3", rx_data); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    logic [9:0]  bits;
    int unsigned t0;
    logic        done;
    send_frame(8'h81, 1'b1, 1'b0, 0);
    send_frame(8'h7E, 1'b1, 1'b0, 2);
    bits = {1'b1, 8'h9E, 1'b0};
    t0   = tick_cnt;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      rx = bits[i];
      for (int j = 0; j < int'(BIT_DIV) && !done; j++) begin
        cyc();
        if (tick_cnt - t0 == 5) done = 1'b1;
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_bit3: got %0d ticks expected 5", tick_cnt - t0); end
    repeat (3) cyc();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (bit_tick !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got tick=%b ferr=%b expected 0 0", bit_tick, frame_err); end
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    rx      = 1'b1;
    repeat (2) cyc();
    reset = 1'b1;
    repeat (4) cyc();
    send_frame(8'hF0, 1'b1, 1'b0, 3);
    n_checks++; if (rx_data !== 8'hF0) begin n_fail++; $display("FAIL rstmid_f0_data: got %h expected f0", rx_data); end
    n_checks++; if (rx_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_f0_status: got valid=%b ovr=%b expected 1 0", rx_valid, overrun); end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic        stop_b;
    logic        ack_load;
    int unsigned gap, t0, f0;
    for (int n = 0; n < 14; n++) begin
      b        = 8'($urandom);
      stop_b   = ($urandom_range(0, 7) != 0);
      ack_load = stop_b && ($urandom_range(0, 3) == 0);
      gap      = stop_b ? $urandom_range(0, 3) : $urandom_range(4, 8);
      t0 = tick_cnt;
      f0 = ferr_cnt;
      send_frame(b, stop_b, ack_load, gap);
      n_checks++; if (rx_data !== m_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", n, rx_data, m_data); end
      n_checks++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, rx_valid, m_valid); end
      n_checks++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun[%0d]: got %b expected %b", n, overrun, m_ovr); end
      n_checks++; if (tick_cnt - t0 != 10) begin n_fail++; $display("FAIL rand_ticks[%0d]: got %0d expected 10", n, tick_cnt - t0); end
      n_checks++; if (ferr_cnt - f0 != (stop_b ? 0 : 1)) begin n_fail++; $display("FAIL rand_ferr[%0d]: got %0d expected %0d", n, ferr_cnt - f0, stop_b ? 0 : 1); end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        n_checks++; if (rx_valid !== m_valid || overrun !== m_ovr) begin n_fail++; $display("FAIL rand_ack[%0d]: got valid=%b ovr=%b expected %b %b", n, rx_valid, overrun, m_valid, m_ovr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_ack_on_load();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "time limit");
  end

endmodule
